// File: rtl/miri_mem_pkg.sv
// Shared types and defaults for the main-memory arbiter that sits between
// the iCache, the dCache and the single main-memory port.
package miri_mem_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int LINE_W_DEF    = 128;
    localparam int LINE_OFF_BITS = $clog2(LINE_W_DEF / 8);

    typedef enum logic [1:0] {
        IDLE,
        IC_XFER,
        DC_XFER,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_t;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Saturating event counter used for the arbiter's per-requester stall counts
// (only instantiated when MEM_ARB_PERF_EN is defined).
module mem_arb_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one main-memory port between iCache fills and dCache fills/writebacks.
// Optional stall counters (ic_wait_cnt, dc_wait_cnt) are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
    import miri_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              mem_err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       ic_wait_cnt,
    output logic [31:0]       dc_wait_cnt
`endif
);

    localparam int OFF_BITS = $clog2(LINE_W / 8);
    localparam int CNT_W    = $clog2(TIMEOUT + 1) + 1;

    arb_state_t        state, state_next;
    owner_t            owner, last_grant, grant_owner;
    logic              bubble;
    logic [CNT_W-1:0]  wait_cnt;
    logic              grant, ack_hit, timeout_hit, in_xfer;
    logic [ADDR_W-1:0] addr_sel;

    assign in_xfer  = (state == IC_XFER) || (state == DC_XFER);
    assign addr_sel = (grant_owner == OWN_DC) ? dc_addr : ic_addr;
    assign mem_req  = in_xfer;
    assign ic_ready = (state == DONE) && (owner == OWN_IC);
    assign dc_ready = (state == DONE) && (owner == OWN_DC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_owner = OWN_IC;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                // The bubble cycle after DONE keeps a still-held req from being regranted at once.
                if (!bubble && (ic_req || dc_req)) begin
                    grant = 1'b1;
                    if (dc_req && (!ic_req || last_grant == OWN_IC)) begin
                        grant_owner = OWN_DC;
                        state_next  = DC_XFER;
                    end else begin
                        grant_owner = OWN_IC;
                        state_next  = IC_XFER;
                    end
                end
            end
            IC_XFER, DC_XFER: begin
                if (mem_ack) begin
                    ack_hit = 1'b1;
                end else if ((TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT))) begin
                    timeout_hit = 1'b1;
                end
                if (ack_hit || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= OWN_IC;
            last_grant <= OWN_IC;
            bubble     <= 1'b0;
            wait_cnt   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ic_rdata   <= '0;
            dc_rdata   <= '0;
            mem_err    <= 1'b0;
        end else begin
            bubble   <= (state == DONE);
            wait_cnt <= in_xfer ? wait_cnt + CNT_W'(1) : '0;
            if (grant) begin
                owner      <= grant_owner;
                last_grant <= grant_owner;
                mem_addr   <= {addr_sel[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
                mem_we     <= (grant_owner == OWN_DC) && dc_we;
                mem_wdata  <= (grant_owner == OWN_DC) ? dc_wdata : '0;
            end
            // A timed-out transfer returns an all-zero line to its owner.
            if (ack_hit || timeout_hit) begin
                if (owner == OWN_DC) begin
                    dc_rdata <= ack_hit ? mem_rdata : '0;
                end else begin
                    ic_rdata <= ack_hit ? mem_rdata : '0;
                end
            end
            if (timeout_hit) begin
                mem_err <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf_cnt #(.W(32)) u_ic_wait (
        .clk   (clk),
        .reset (reset),
        .inc   (ic_req && !ic_ready),
        .count (ic_wait_cnt)
    );

    mem_arb_perf_cnt #(.W(32)) u_dc_wait (
        .clk   (clk),
        .reset (reset),
        .inc   (dc_req && !dc_ready),
        .count (dc_wait_cnt)
    );
`else
    // Stall counters are not built; arbitration is unaffected.
`endif

endmodule
